// File: rtl/pipo_rr_arbiter.sv
// rtl/pipo_rr_arbiter.sv - round-robin load sequencer for a shared PIPO register (optional q_par via PIPO_ARB_PARITY_EN)
module pipo_rr_arbiter #(
  parameter int NREQ        = 4,
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    data,
  output logic [NREQ-1:0]          gnt,
  output logic [WIDTH-1:0]         q,
  output logic                     q_valid,
  output logic [$clog2(NREQ)-1:0]  q_owner,
`ifdef PIPO_ARB_PARITY_EN
  output logic                     q_par,
`endif
  output logic                     busy
);

  localparam int OWNER_W = $clog2(NREQ);
  localparam logic [3:0] HOLD_INIT = (HOLD_CYCLES > 0) ? 4'(HOLD_CYCLES - 1) : 4'd0;
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HOLD
  } state_t;

  state_t               state;
  logic [OWNER_W-1:0]   last_owner;
  logic [OWNER_W-1:0]   winner;
  logic [OWNER_W-1:0]   cand;
  logic [3:0]           cnt;

  // Rotating priority search: scan downward in distance so the nearest requester after last_owner wins.
  always_comb begin
    winner = last_owner;
    cand   = last_owner;
    for (int i = NREQ; i >= 1; i--) begin
      cand = OWNER_W'((int'(last_owner) + i) % NREQ);
      if (req[cand]) winner = cand;
    end
  end

  // Sequencer: grant for one cycle, capture the owner's word, then hold before re-arbitrating.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      gnt        <= '0;
      q          <= '0;
      q_valid    <= 1'b0;
      q_owner    <= '0;
      busy       <= 1'b0;
      last_owner <= OWNER_W'(NREQ - 1);
      cnt        <= 4'd0;
`ifdef PIPO_ARB_PARITY_EN
      q_par      <= 1'b0;
`endif
    end else begin
      q_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|req) begin
            gnt     <= ONE << winner;
            q_owner <= winner;
            busy    <= 1'b1;
            state   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          q          <= data[q_owner*WIDTH +: WIDTH];
`ifdef PIPO_ARB_PARITY_EN
          q_par      <= ^data[q_owner*WIDTH +: WIDTH];
`endif
          q_valid    <= 1'b1;
          gnt        <= '0;
          last_owner <= q_owner;
          if (HOLD_CYCLES > 0) begin
            cnt   <= HOLD_INIT;
            state <= ST_HOLD;
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (cnt == 4'd0) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          gnt   <= '0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/pipo_rr_arbiter.md
# pipo_rr_arbiter

Round-robin arbiter and load sequencer that shares one WIDTH-bit parallel-in/parallel-out register between NREQ requesters. It selects one requester at a time and issues a one-cycle grant. It captures that requester's parallel word into the shared register and then holds the value for a programmable number of cycles before it re-arbitrates. It sits directly in front of the shared PIPO datapath register and replaces ad-hoc load muxing by the requesting blocks.

## Interface
- NREQ, 4, number of requesters; legal range 2..8.
- WIDTH, 8, data width of the shared register.
- HOLD_CYCLES, 2, idle cycles after each load before the next grant; legal range 0..15.
- clk  input  1  clock, all state on rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- req  input  NREQ  per-requester load request, level-sensitive.
- data  input  NREQ*WIDTH  flattened words; requester k occupies bits [k*WIDTH +: WIDTH].
- gnt  output  NREQ  registered one-hot grant; at most one bit set.
- q  output  WIDTH  shared register contents.
- q_valid  output  1  one-cycle pulse; q was loaded on the preceding edge.
- q_owner  output  clog2(NREQ)  index of the requester whose word is in q.
- busy  output  1  high in LOAD and HOLD states.

## Operation
- FSM states: IDLE, LOAD, HOLD.
- IDLE:
  - If req != 0, pick the winner as the first set req bit searching upward from (last_owner+1) mod NREQ, wrapping.
  - At the edge: gnt <= onehot(winner), q_owner <= winner, state -> LOAD.
  - If req == 0, stay in IDLE.
- LOAD (exactly 1 cycle, gnt high):
  - At the edge: q <= data[q_owner], q_valid <= 1, gnt <= 0, last_owner <= q_owner.
  - Next state is HOLD with cnt <= HOLD_CYCLES-1 when HOLD_CYCLES > 0; otherwise IDLE.
- HOLD:
  - cnt decrements each cycle; when cnt == 0, state -> IDLE.
  - req is ignored in HOLD.
- Handshake:
  - A requester keeps req and its data stable until it observes gnt[k]=1.
  - Data is sampled at the rising edge that ends the gnt cycle.
  - The requester may drop or change req/data from the following cycle.
- A requester that drops req while its gnt is high still has data[owner] loaded. This is defined behaviour, not an error.
- The next arbitration for the same requester needs req re-asserted, or still held, in IDLE.
- Fairness: with all req bits held high, owners rotate 0,1,2,…,NREQ-1,0,…
- Reset values: state IDLE, gnt 0, q 0, q_valid 0, q_owner 0, busy 0, last_owner NREQ-1 (so requester 0 has first priority), cnt 0.
- Reset mid-operation clears everything immediately and asynchronously, including an in-flight grant. No load completes.

## Timing
- req sampled high at edge E (state IDLE) gives:
  - gnt high after E for one cycle;
  - q updated at E+1;
  - q_valid high between E+1 and E+2.
- busy is high from E to the edge where the FSM returns to IDLE.
- Load period per grant is 2 + HOLD_CYCLES cycles (IDLE, LOAD, HOLD×n). With continuous requests, the next gnt rises at E+2+HOLD_CYCLES.
- q changes only at the LOAD edge and is stable at all other times.

## Configuration
- PIPO_ARB_PARITY_EN defined:
  - Adds output q_par (1 bit), the even parity (XOR reduction) of the word loaded into q.
  - q_par is registered on the same edge as q and resets to 0.
- PIPO_ARB_PARITY_EN undefined: port q_par and its logic are absent. All other behaviour is identical.

## Test plan
- Reset check:
  - Hold reset_n=0 with req=4'b1111 → gnt=0, q=0, q_valid=0, busy=0.
  - After release, first grant goes to requester 0.
- Single requester:
  - req=4'b0100 with data[2]=8'hA5 → gnt=4'b0100 for 1 cycle, then q=8'hA5, q_owner=2, q_valid pulse of 1 cycle.
  - q is checked bit-exact, all 8 bits including MSB.
- Round robin with HOLD_CYCLES=2:
  - req=4'b1111 held, data k = 8'h80|k → grants in order 0,1,2,3,0.
  - Consecutive gnt rising edges are exactly 4 cycles apart.
  - q sequence is 8'h80, 8'h81, 8'h82, 8'h83.
- Skip and wrap: last_owner=3, req=4'b0110 → requester 1 is granted, then requester 2, then requester 1.
- Reset mid-operation:
  - Assert reset_n=0 while gnt=4'b0010 → gnt drops immediately and q stays 0.
  - After release, requester 0 wins if requesting.
- Parity (PIPO_ARB_PARITY_EN defined): load 8'hFF → q_par=0; load 8'h80 → q_par=1, aligned with q_valid.
